// File: rtl/hwag_tooth_sync.sv
// Tooth-period measurement and missing-tooth synchronisation for the angle generator.
// Optional sync-error counter enabled by defining HWAG_TOOTH_SYNC_ERRCNT_EN.
module hwag_tooth_sync #(
    parameter int CNT_W   = 24,
    parameter int TOOTH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               cap_edge,
    input  logic [TOOTH_W-1:0] teeth_total,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   period_prev,
    output logic [TOOTH_W-1:0] tooth_num,
    output logic               tooth_pulse,
    output logic               gap_pulse,
    output logic               sync,
    output logic               sync_err,
    output logic               stall,
    output logic [7:0]         err_cnt,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        CHECK = 2'd2,
        SYNC  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   pcnt;
    logic               per_valid;
    logic [CNT_W-1:0]   period_new;
    logic [CNT_W:0]     gap_limit;
    logic               is_gap;
    logic               pcnt_max;
    logic               at_end;

    // Gap when the new period exceeds 1.5x the last one; one extra bit avoids overflow.
    assign period_new = pcnt + 1'b1;
    assign gap_limit  = {1'b0, period} + {2'b00, period[CNT_W-1:1]};
    assign is_gap     = {1'b0, period_new} > gap_limit;
    assign pcnt_max   = &pcnt;
    assign at_end     = tooth_num >= teeth_total;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (!rst || !ena) begin
            state       <= IDLE;
            pcnt        <= '0;
            per_valid   <= 1'b0;
            period      <= '0;
            period_prev <= '0;
            tooth_num   <= '0;
            tooth_pulse <= 1'b0;
            gap_pulse   <= 1'b0;
            sync        <= 1'b0;
            sync_err    <= 1'b0;
            stall       <= 1'b0;
        end else begin
            tooth_pulse <= 1'b0;
            gap_pulse   <= 1'b0;
            sync_err    <= 1'b0;
            if (state != IDLE && pcnt_max) begin
                // Engine stopped: drop lock and wait for the wheel to restart.
                state     <= IDLE;
                stall     <= 1'b1;
                sync      <= 1'b0;
                tooth_num <= '0;
                pcnt      <= '0;
            end else if (cap_edge) begin
                stall <= 1'b0;
                pcnt  <= '0;
                if (state == IDLE) begin
                    state     <= SEEK;
                    per_valid <= 1'b0;
                end else begin
                    tooth_pulse <= 1'b1;
                    period      <= period_new;
                    period_prev <= period;
                    per_valid   <= 1'b1;
                    case (state)
                        SEEK: begin
                            if (per_valid && is_gap) begin
                                gap_pulse <= 1'b1;
                                tooth_num <= TOOTH_W'(1);
                                state     <= CHECK;
                            end
                        end
                        default: begin
                            // CHECK and SYNC share the gap-position rules.
                            if (at_end) begin
                                if (is_gap) begin
                                    gap_pulse <= 1'b1;
                                    tooth_num <= TOOTH_W'(1);
                                    state     <= SYNC;
                                    sync      <= 1'b1;
                                end else begin
                                    sync_err  <= 1'b1;
                                    tooth_num <= '0;
                                    state     <= SEEK;
                                    sync      <= 1'b0;
                                end
                            end else if (is_gap) begin
                                gap_pulse <= 1'b1;
                                sync_err  <= 1'b1;
                                tooth_num <= TOOTH_W'(1);
                                state     <= CHECK;
                                sync      <= 1'b0;
                            end else begin
                                tooth_num <= tooth_num + 1'b1;
                            end
                        end
                    endcase
                end
            end else if (state != IDLE) begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

`ifdef HWAG_TOOTH_SYNC_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst || !ena) begin
            err_cnt <= '0;
        end else if (sync_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Directed bench for hwag_tooth_sync: a 24-bit instance for lock/error/reset
// scenarios and an 8-bit instance for counter saturation.
module tb_hwag_tooth_sync;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEEK  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_SYNC  = 2'd3;

  logic clk = 1'b0;
  logic rst, ena, cap_edge, cap8;
  logic [7:0] teeth_total;

  logic [23:0] period, period_prev;
  logic [7:0]  tooth_num, err_cnt;
  logic        tooth_pulse, gap_pulse, sync, sync_err, stall;
  logic [1:0]  fsm_state;

  logic [7:0]  period_s, period_prev_s;
  logic [7:0]  tooth_num_s, err_cnt_s;
  logic        tooth_pulse_s, gap_pulse_s, sync_s, sync_err_s, stall_s;
  logic [1:0]  fsm_state_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hwag_tooth_sync #(.CNT_W(24), .TOOTH_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cap_edge(cap_edge), .teeth_total(teeth_total),
    .period(period), .period_prev(period_prev), .tooth_num(tooth_num),
    .tooth_pulse(tooth_pulse), .gap_pulse(gap_pulse), .sync(sync), .sync_err(sync_err),
    .stall(stall), .err_cnt(err_cnt), .fsm_state(fsm_state)
  );

  hwag_tooth_sync #(.CNT_W(8), .TOOTH_W(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .cap_edge(cap8), .teeth_total(teeth_total),
    .period(period_s), .period_prev(period_prev_s), .tooth_num(tooth_num_s),
    .tooth_pulse(tooth_pulse_s), .gap_pulse(gap_pulse_s), .sync(sync_s), .sync_err(sync_err_s),
    .stall(stall_s), .err_cnt(err_cnt_s), .fsm_state(fsm_state_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One edge n cycles after the previous one (period n); outputs are settled on return.
  task automatic pulse(input int n, input bit which);
    repeat (n - 1) tick();
    if (which) cap8 = 1'b1; else cap_edge = 1'b1;
    tick();
    cap8 = 1'b0;
    cap_edge = 1'b0;
  endtask

  // Wake from IDLE, one reference period, then the first gap.
  task automatic seek_to_gap(input bit which, input int nper, input int gper);
    pulse(5, which);
    pulse(nper, which);
    pulse(gper, which);
  endtask

  // Teeth 2..58 then the gap closing the revolution.
  task automatic finish_rev(input bit which, input int nper, input int gper);
    repeat (57) pulse(nper, which);
    pulse(gper, which);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"},    period, 0);
    check({tag, "_prev"},      period_prev, 0);
    check({tag, "_tooth"},     tooth_num, 0);
    check({tag, "_pulses"},    {tooth_pulse, gap_pulse, sync_err}, 0);
    check({tag, "_sync"},      sync, 0);
    check({tag, "_stall"},     stall, 0);
    check({tag, "_err_cnt"},   err_cnt, 0);
    check({tag, "_state"},     fsm_state, S_IDLE);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; cap_edge = 1'b0; cap8 = 1'b0; teeth_total = 8'd58;
    repeat (2) tick();
    check_zero("reset");
    check("reset_state8", fsm_state_s, S_IDLE);
    rst = 1'b1;
    tick();

    // Saturation on the 8-bit instance after locking with 10/30 cycle teeth.
    seek_to_gap(1'b1, 10, 30);
    check("s8_first_gap", gap_pulse_s, 1);
    finish_rev(1'b1, 10, 30);
    check("s8_sync", sync_s, 1);
    repeat (255) tick();
    check("s8_stall_pre", stall_s, 0);
    check("s8_state_pre", fsm_state_s, S_SYNC);
    tick();
    check("s8_stall", stall_s, 1);
    check("s8_sync_drop", sync_s, 0);
    check("s8_tooth_clr", tooth_num_s, 0);
    check("s8_state_idle", fsm_state_s, S_IDLE);
    pulse(3, 1'b1);
    check("s8_stall_clr", stall_s, 0);
    check("s8_state_seek", fsm_state_s, S_SEEK);
    check("s8_no_pulse_idle", tooth_pulse_s, 0);
    check("main_idle_meanwhile", fsm_state, S_IDLE);

    // 60-2 lock.
    pulse(5, 1'b0);
    check("idle_edge_state", fsm_state, S_SEEK);
    check("idle_edge_nopulse", tooth_pulse, 0);
    check("idle_edge_period", period, 0);
    pulse(100, 1'b0);
    check("seek_period", period, 100);
    check("seek_tpulse", tooth_pulse, 1);
    check("seek_nogap", gap_pulse, 0);
    pulse(300, 1'b0);
    check("gap1_pulse", gap_pulse, 1);
    check("gap1_tooth", tooth_num, 1);
    check("gap1_sync", sync, 0);
    check("gap1_period", period, 300);
    check("gap1_state", fsm_state, S_CHECK);
    repeat (57) pulse(100, 1'b0);
    check("rev_tooth58", tooth_num, 58);
    check("rev_period", period, 100);
    check("rev_prev", period_prev, 100);
    pulse(300, 1'b0);
    check("gap2_sync", sync, 1);
    check("gap2_pulse", gap_pulse, 1);
    check("gap2_tooth", tooth_num, 1);
    check("gap2_period", period, 300);
    check("gap2_state", fsm_state, S_SYNC);
    tick();
    check("gap_pulse_1cyc", gap_pulse, 0);
    pulse(99, 1'b0);
    check("sync_period", period, 100);
    check("sync_prev", period_prev, 300);
    check("sync_tooth2", tooth_num, 2);

    // Missing gap: the 59th edge of the revolution (gap edge counted as first) is normal.
    repeat (56) pulse(100, 1'b0);
    check("miss_pre_sync", sync, 1);
    check("miss_pre_tooth", tooth_num, 58);
    pulse(100, 1'b0);
    check("miss_err", sync_err, 1);
    check("miss_sync", sync, 0);
    check("miss_tooth", tooth_num, 0);
    check("miss_state", fsm_state, S_SEEK);
    tick();
    check("miss_err_1cyc", sync_err, 0);

    pulse(299, 1'b0);
    check("relock_gap_state", fsm_state, S_CHECK);
    finish_rev(1'b0, 100, 300);
    check("relock_sync", sync, 1);

    // Early gap at tooth 40.
    repeat (39) pulse(100, 1'b0);
    check("early_pre_tooth", tooth_num, 40);
    pulse(300, 1'b0);
    check("early_err", sync_err, 1);
    check("early_sync", sync, 0);
    check("early_tooth", tooth_num, 1);
    check("early_state", fsm_state, S_CHECK);
    finish_rev(1'b0, 100, 300);
    check("early_resync", sync, 1);
    check("early_resync_tooth", tooth_num, 1);

    // One-cycle reset while locked.
    pulse(100, 1'b0);
    pulse(100, 1'b0);
    check("pre_rst_tooth", tooth_num, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_zero("midrst");
    seek_to_gap(1'b0, 100, 300);
    check("rst_relock_gap1_sync", sync, 0);
    check("rst_relock_gap1_tooth", tooth_num, 1);
    finish_rev(1'b0, 100, 300);
    check("rst_relock_sync", sync, 1);

    // One-cycle enable drop while locked.
    ena = 1'b0;
    tick();
    ena = 1'b1;
    check_zero("ena_low");
    seek_to_gap(1'b0, 100, 300);
    check("ena_relock_gap1_sync", sync, 0);
    finish_rev(1'b0, 100, 300);
    check("ena_relock_sync", sync, 1);

    // Repeated early gaps (period 4 then 10): every second edge is a mismatch.
    for (int i = 0; i < 10; i++) begin
      pulse(4, 1'b0);
      pulse(10, 1'b0);
    end
    check("mm10_err", sync_err, 1);
    tick();
`ifdef HWAG_TOOTH_SYNC_ERRCNT_EN
    check("err_cnt_10", err_cnt, 10);
`else
    check("err_cnt_10", err_cnt, 0);
`endif
    for (int i = 0; i < 290; i++) begin
      pulse(4, 1'b0);
      pulse(10, 1'b0);
    end
    tick();
`ifdef HWAG_TOOTH_SYNC_ERRCNT_EN
    check("err_cnt_sat", err_cnt, 255);
`else
    check("err_cnt_sat", err_cnt, 0);
`endif
    check("mm_state", fsm_state, S_CHECK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
